// File: rtl/h3_pkg.sv
// Shared Hamming(7,4) types and codeword bit positions.
// Bit index in a codeword is Hamming position minus one.
package h3_pkg;

  localparam int H3_N = 7;
  localparam int H3_K = 4;
  localparam int H3_R = 3;

  typedef logic [H3_N-1:0] h3_cw_t;
  typedef logic [H3_K-1:0] h3_nibble_t;

  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int P4_POS = 3;
  localparam int D0_POS = 2;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  typedef enum logic {
    H3_IDLE = 1'b0,
    H3_SEND = 1'b1
  } h3_state_t;

endpackage

// File: rtl/h3_encode_7_4.sv
// Combinational Hamming(7,4) nibble encoder.
// Layout matches the h3_correct_7_4 corrector.
import h3_pkg::*;

module h3_encode_7_4 (
  input  h3_nibble_t d_i,
  output h3_cw_t     cw_o
);

  always_comb begin
    cw_o         = '0;
    cw_o[D0_POS] = d_i[0];
    cw_o[D1_POS] = d_i[1];
    cw_o[D2_POS] = d_i[2];
    cw_o[D3_POS] = d_i[3];
    cw_o[P1_POS] = d_i[0] ^ d_i[1] ^ d_i[3];
    cw_o[P2_POS] = d_i[0] ^ d_i[2] ^ d_i[3];
    cw_o[P4_POS] = d_i[1] ^ d_i[2] ^ d_i[3];
  end

endmodule

// File: rtl/h3_encode_stream_7_4.sv
// Streaming Hamming(7,4) encoder, OUT_CW codewords per beat.
// H3_ENCODE_ERR_INJECT_EN adds output bit-flip injection ports.
import h3_pkg::*;

module h3_encode_stream_7_4 #(
  parameter int DATA_W = 16,
  parameter int OUT_CW = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [7*OUT_CW-1:0]   code_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  first_o,
  output logic                  last_o
`ifdef H3_ENCODE_ERR_INJECT_EN
  ,
  input  logic                  inj_en_i,
  input  logic [2:0]            inj_pos_i,
  input  logic [(OUT_CW>1 ? $clog2(OUT_CW) : 1)-1:0] inj_cw_i
`endif
);

  localparam int NIBBLES = DATA_W / 4;
  localparam int BEATS   = NIBBLES / OUT_CW;
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW_W    = (OUT_CW > 1) ? $clog2(OUT_CW) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  h3_state_t                        state;
  logic [BW-1:0]                    beat;
  logic [BEATS-1:0][4*OUT_CW-1:0]   hold;
  logic [4*OUT_CW-1:0]              beat_nibs;
  logic                             xfer;
  logic                             accept;

  // ready_o is a combinational path from ready_i: a word can be
  // taken on the last-beat handoff so back-to-back words need no bubble.
  assign xfer      = valid_o && ready_i;
  assign ready_o   = rst_n_i && ((state == H3_IDLE) || (xfer && last_o));
  assign accept    = valid_i && ready_o;
  assign beat_nibs = hold[beat];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= H3_IDLE;
      beat    <= '0;
      hold    <= '0;
      valid_o <= 1'b0;
      first_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          hold    <= data_i;
          beat    <= '0;
          state   <= H3_SEND;
          valid_o <= 1'b1;
          first_o <= 1'b1;
          last_o  <= (BEATS == 1);
        end
        xfer && !last_o: begin
          beat    <= beat + 1'b1;
          first_o <= 1'b0;
          last_o  <= (beat + 1'b1 == LAST_BEAT);
        end
        xfer && last_o && !accept: begin
          state   <= H3_IDLE;
          beat    <= '0;
          valid_o <= 1'b0;
          first_o <= 1'b0;
          last_o  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  for (genvar j = 0; j < OUT_CW; j++) begin : g_cw
    h3_cw_t cw;

    h3_encode_7_4 u_enc (
      .d_i  (beat_nibs[4*j +: 4]),
      .cw_o (cw)
    );

`ifdef H3_ENCODE_ERR_INJECT_EN
    logic hit;
    assign hit = valid_o && inj_en_i && (inj_pos_i != 3'd0)
              && (inj_cw_i == CW_W'(j));
    assign code_o[7*j +: 7] =
      hit ? (cw ^ (h3_cw_t'(1) << (inj_pos_i - 3'd1))) : cw;
`else
    assign code_o[7*j +: 7] = cw;
`endif
  end

endmodule

// File: tb/tb_h3_encode_stream_7_4.sv
// Scoreboard bench for h3_encode_stream_7_4 (DATA_W=16, OUT_CW=2).
// Injection steps run only when H3_ENCODE_ERR_INJECT_EN is defined.
`timescale 1ns/1ps
import h3_pkg::*;

module tb_h3_encode_stream_7_4;

  localparam int DATA_W = 16;
  localparam int OUT_CW = 2;
  localparam int BEATS  = DATA_W / 4 / OUT_CW;
  localparam int CWW    = 7 * OUT_CW;

  typedef struct packed {
    logic [CWW-1:0] code;
    logic           first;
    logic           last;
  } beat_t;

  logic              clk_i;
  logic              rst_n_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic [CWW-1:0]    code_o;
  logic              valid_o;
  logic              ready_i;
  logic              first_o;
  logic              last_o;
  logic [3:0]        sw_nib;
  h3_cw_t            sw_cw;
`ifdef H3_ENCODE_ERR_INJECT_EN
  logic              inj_en_i;
  logic [2:0]        inj_pos_i;
  logic [0:0]        inj_cw_i;
`endif

  beat_t sb[$];
  int    checks   = 0;
  int    failures = 0;
  logic  rand_rdy = 1'b0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  h3_encode_stream_7_4 #(
    .DATA_W (DATA_W),
    .OUT_CW (OUT_CW)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .code_o  (code_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .first_o (first_o),
    .last_o  (last_o)
`ifdef H3_ENCODE_ERR_INJECT_EN
    ,
    .inj_en_i  (inj_en_i),
    .inj_pos_i (inj_pos_i),
    .inj_cw_i  (inj_cw_i)
`endif
  );

  h3_encode_7_4 u_sweep (
    .d_i  (sw_nib),
    .cw_o (sw_cw)
  );

  // Reference: data at Hamming positions 3,5,6,7; parity k covers i&k.
  function automatic h3_cw_t model_enc(input logic [3:0] d);
    logic [7:1] p;
    p    = '0;
    p[3] = d[0];
    p[5] = d[1];
    p[6] = d[2];
    p[7] = d[3];
    for (int k = 1; k <= 4; k = k * 2)
      for (int i = 3; i <= 7; i++)
        if (i != 4 && (i & k) != 0) p[k] = p[k] ^ p[i];
    return p;
  endfunction

  function automatic logic [2:0] syndrome(input h3_cw_t cw);
    logic [2:0] s;
    s = '0;
    for (int i = 1; i <= 7; i++)
      if (cw[i-1]) s = s ^ 3'(i);
    return s;
  endfunction

  function automatic beat_t exp_beat(input logic [DATA_W-1:0] w,
                                     input int b);
    beat_t e;
    e.code = '0;
    for (int j = 0; j < OUT_CW; j++)
      e.code[7*j +: 7] = model_enc(w[4*(b*OUT_CW+j) +: 4]);
    e.first = (b == 0);
    e.last  = (b == BEATS - 1);
    return e;
  endfunction

  function automatic void push_word(input logic [DATA_W-1:0] w);
    for (int b = 0; b < BEATS; b++) sb.push_back(exp_beat(w, b));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin : mon
    beat_t e;
    if (rst_n_i && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_beat observed=%0h expected=none", code_o);
      end else begin
        e = sb.pop_front();
        chk("beat_code", 32'(code_o), 32'(e.code));
        chk("beat_first", 32'(first_o), 32'(e.first));
        chk("beat_last", 32'(last_o), 32'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [DATA_W-1:0] w, input bit do_push);
    bit ok;
    ok      = 1'b0;
    data_i  = w;
    valid_i = 1'b1;
    if (do_push) push_word(w);
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk_i);
      if (ready_o) ok = 1'b1;
      tick();
    end
    valid_i = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk_i);
      if (sb.size() == 0 && !valid_o) done = 1'b1;
      else tick();
    end
    chk("drain", 32'(done), 32'd1);
    tick();
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    beat_t e0;
    rst_n_i = 1'b0;
    data_i  = '0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    sw_nib  = '0;
`ifdef H3_ENCODE_ERR_INJECT_EN
    inj_en_i  = 1'b0;
    inj_pos_i = '0;
    inj_cw_i  = '0;
`endif
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_first", 32'(first_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    chk("rst_code", 32'(code_o), 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("idle_ready", 32'(ready_o), 32'd1);
    chk("idle_valid", 32'(valid_o), 32'd0);

    for (int n = 0; n < 16; n++) begin
      sw_nib = 4'(n);
      #1;
      chk("enc_model", 32'(sw_cw), 32'(model_enc(4'(n))));
      chk("enc_syndrome", 32'(syndrome(sw_cw)), 32'd0);
    end
    sw_nib = 4'h1; #1 chk("enc_1", 32'(sw_cw), 32'h07);
    sw_nib = 4'hB; #1 chk("enc_b", 32'(sw_cw), 32'h55);
    sw_nib = 4'hF; #1 chk("enc_f", 32'(sw_cw), 32'h7F);
    tick();

    send(16'h0F0B, 1'b1);
    chk("w0_b0_code", 32'(code_o), 32'h0055);
    chk("w0_b0_first", 32'(first_o), 32'd1);
    tick();
    chk("w0_b1_code", 32'(code_o), 32'h007F);
    chk("w0_b1_last", 32'(last_o), 32'd1);
    drain();

    push_word(16'h1234);
    push_word(16'hA5C3);
    data_i  = 16'h1234;
    valid_i = 1'b1;
    @(negedge clk_i); chk("b2b_rdy_idle", 32'(ready_o), 32'd1);
    tick(); data_i = 16'hA5C3;
    @(negedge clk_i);
    chk("b2b_v0", 32'(valid_o), 32'd1);
    chk("b2b_r0", 32'(ready_o), 32'd0);
    tick();
    @(negedge clk_i);
    chk("b2b_v1", 32'(valid_o), 32'd1);
    chk("b2b_r1", 32'(ready_o), 32'd1);
    tick(); valid_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_v2", 32'(valid_o), 32'd1);
    chk("b2b_r2", 32'(ready_o), 32'd0);
    tick();
    @(negedge clk_i);
    chk("b2b_v3", 32'(valid_o), 32'd1);
    chk("b2b_r3", 32'(ready_o), 32'd1);
    tick();
    @(negedge clk_i);
    chk("b2b_end_v", 32'(valid_o), 32'd0);
    chk("b2b_end_r", 32'(ready_o), 32'd1);
    tick();
    drain();

    data_i  = 16'h7E19;
    valid_i = 1'b1;
    push_word(16'h7E19);
    e0 = sb[0];
    @(negedge clk_i); chk("stall_rdy", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("stall_code", 32'(code_o), 32'(e0.code));
      chk("stall_first", 32'(first_o), 32'd1);
      chk("stall_last", 32'(last_o), 32'd0);
      chk("stall_valid", 32'(valid_o), 32'd1);
      chk("stall_ready", 32'(ready_o), 32'd0);
    end
    tick();
    ready_i = 1'b1;
    drain();

    send(16'hBEEF, 1'b1);
    tick();
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_first", 32'(first_o), 32'd0);
    chk("mid_rst_last", 32'(last_o), 32'd0);
    chk("mid_rst_code", 32'(code_o), 32'd0);
    sb.delete();
    tick();
    tick();
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", 32'(ready_o), 32'd1);
    chk("post_rst_valid", 32'(valid_o), 32'd0);
    tick();
    send(16'h4D2A, 1'b1);
    chk("post_rst_first", 32'(first_o), 32'd1);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 6; i++) send(16'($urandom), 1'b1);
    rand_rdy = 1'b0;
    ready_i  = 1'b1;
    drain();

`ifdef H3_ENCODE_ERR_INJECT_EN
    inj_en_i  = 1'b1;
    inj_pos_i = 3'd5;
    inj_cw_i  = 1'b0;
    e0 = exp_beat(16'h000B, 0);
    e0.code[6:0] = e0.code[6:0] ^ 7'h10;
    sb.push_back(e0);
    sb.push_back(exp_beat(16'h000B, 1));
    send(16'h000B, 1'b0);
    chk("inj_cw0", 32'(code_o[6:0]), 32'h45);
    chk("inj_synd", 32'(syndrome(code_o[6:0])), 32'd5);
    inj_en_i = 1'b0;
    drain();
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
